player_sprite_fetch: RTL and testbench
======================================

// Module: player_sprite_fetch
// PURPOSE
//  Upstream stage of the colour mapper. Turns the current pixel (DrawX/DrawY) and the
//  player position into a sprite-ROM address, reads the ROM and drives is_player and
//  stand_data_out (5-bit palette index).
//  Also owns the player animation FSM (stand/walk/jump poses) and optional horizontal mirroring.
// PARAMETERS
//  SPR_W      32  sprite width in pixels (power of 2)
//  SPR_H      48  sprite height in pixels
//  N_FRAMES   4   poses stacked vertically in ROM: 0=stand, 1..N_FRAMES-2=walk, N_FRAMES-1=jump
//  FRAME_HOLD 8   VGA frames each walk pose is held (>=1)
//  ADDR_W     13  ROM address width; must cover N_FRAMES*SPR_H*SPR_W
// PORTS
//  Clk            in   1       pixel-domain clock
//  Reset          in   1       asynchronous, active-high reset
//  frame_start    in   1       1-cycle pulse per VGA frame (vsync edge)
//  DrawX, DrawY   in   10 ea   current pixel coordinate
//  PlayerX,PlayerY in  10 ea   top-left corner of player sprite
//  moving         in   1       player walking horizontally
//  jumping        in   1       player airborne
//  facing_left    in   1       player faces left
//  rom_addr       out  ADDR_W  sprite-ROM address (synchronous ROM, 1-cycle read latency)
//  rom_data       in   5       palette index returned by ROM
//  is_player      out  1       pixel lies inside sprite box
//  stand_data_out out  5       palette index for this pixel; 0 = transparent
// BEHAVIOUR
//  - Reset (async, active-high): rom_addr=0, is_player=0, stand_data_out=0, state=IDLE,
//    pose=0, hold_cnt=0, latched facing=0.
//  - FSM updates ONLY on cycles with frame_start=1. On all other cycles, pose is frozen (no mid-frame tearing).
//    States: IDLE (pose 0), WALK (pose 1..N_FRAMES-2), JUMP (pose N_FRAMES-1).
//    Next state priority: jumping -> JUMP; else moving -> WALK; else IDLE.
//    Entering WALK from another state: pose=1, hold_cnt=0.
//    In WALK: hold_cnt++. When hold_cnt==FRAME_HOLD-1: hold_cnt=0, pose++, with wrap N_FRAMES-2 -> 1.
//    Leaving WALK clears hold_cnt.
//    facing_left is latched on the same frame_start.
//  - Hit test (11-bit arithmetic, no wrap at the right/bottom edge):
//    hit = DrawX>=PlayerX && DrawX<PlayerX+SPR_W && DrawY>=PlayerY && DrawY<PlayerY+SPR_H.
//  - rel_x = DrawX-PlayerX, rel_y = DrawY-PlayerY.
//    col = (flip && latched facing) ? SPR_W-1-rel_x : rel_x.
//    addr = (pose*SPR_H + rel_y)*SPR_W + col.
//  - Pipeline stage 0 (cycle N): register rom_addr = hit ? addr : 0. Register hit into hit_d.
//  - Stage 1 (cycle N+1): ROM presents rom_data.
//    Register is_player = hit_d; stand_data_out = hit_d ? rom_data : 0.
//  - Latency: is_player/stand_data_out appear 2 clocks after DrawX/DrawY.
//    The top level delays DrawX/DrawY and other layers by 2 to stay aligned.
//  - Sprite partially off-screen (PlayerX>=640-SPR_W): only on-screen pixels hit; no wrap to x=0.
//  - frame_start coinciding with an in-sprite pixel: that pixel uses the old pose.
//    The new pose applies from the next cycle.
//  - Reset mid-frame: pipeline outputs forced to 0 immediately; resumes with IDLE pose.
// CONFIGURATION
//  SPRITE_FLIP_EN defined: facing_left mirrors the sprite horizontally as above.
//  Not defined: facing_left is ignored, col = rel_x always, and the latch is removed.
// TESTING
//  1. Reset asserted mid-line with is_player=1
//     -> is_player, stand_data_out, rom_addr all 0 same cycle; pose=0 after release.
//  2. PlayerX=100,PlayerY=200, idle, DrawX=100,DrawY=200
//     -> rom_addr=0 next clk; is_player=1, stand_data_out=ROM[0] 2 clks later.
//     DrawX=132 -> is_player=0, stand_data_out=0.
//  3. moving=1, FRAME_HOLD=8: 8 frame_starts per pose.
//     Sequence 1,2,1,2 (N_FRAMES=4); pose-1 addr at rel 0,0 = 1536.
//  4. moving=1 and jumping=1 at same frame_start -> JUMP, pose 3, addr at rel 0,0 = 4608.
//     Drop both -> IDLE pose 0.
//  5. SPRITE_FLIP_EN, facing_left=1 latched, rel_x=0,rel_y=0, IDLE -> rom_addr=31.
//     Without macro -> rom_addr=0.
//  6. PlayerX=620, DrawX=639 -> hit; DrawX=0 same line -> no hit (no wrap).

Source files
------------

// File: rtl/player_sprite_fetch.sv
// player_sprite_fetch
//   Upstream stage of the colour mapper. Converts the current pixel and the
//   player's top-left corner into a sprite-ROM address, and returns the hit
//   flag and the palette index two clocks after DrawX/DrawY. It also owns the
//   player animation FSM: IDLE pose 0, WALK poses 1..N_FRAMES-2, JUMP pose
//   N_FRAMES-1.
//
//   Optional feature macro: SPRITE_FLIP_EN
//     defined   : facing_left is latched on frame_start and, when set, mirrors
//                 the sprite horizontally.
//     undefined : facing_left is ignored and columns are never mirrored.
module player_sprite_fetch #(
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 48,
    parameter int N_FRAMES   = 4,
    parameter int FRAME_HOLD = 8,
    parameter int ADDR_W     = 13
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        PlayerX,
    input  logic [9:0]        PlayerY,
    input  logic              moving,
    input  logic              jumping,
    input  logic              facing_left,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [4:0]        rom_data,
    output logic              is_player,
    output logic [4:0]        stand_data_out
);

    localparam int POSE_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WALK,
        ST_JUMP
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [POSE_W-1:0]   r_pose;
    logic [POSE_W-1:0]   w_pose_nx;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_nx;

    logic [10:0]         w_x_end;
    logic [10:0]         w_y_end;
    logic                w_hit;
    logic [9:0]          w_rel_x;
    logic [9:0]          w_rel_y;
    logic [ADDR_W-1:0]   w_col;
    logic [ADDR_W-1:0]   w_row;
    logic [ADDR_W-1:0]   w_addr;

    logic [ADDR_W-1:0]   r_rom_addr;
    logic                r_hit_d;
    logic                r_is_player;
    logic [4:0]          r_stand_data;

    // Animation state register; only moves when the next-state logic says so.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_pose     <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_pose     <= w_pose_nx;
            r_hold_cnt <= w_hold_nx;
        end
    end

    // Next-state logic: pose is frozen except on the frame_start cycle.
    // NOTE: every output gets a default first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nx = r_state;
        w_pose_nx  = r_pose;
        w_hold_nx  = r_hold_cnt;
        if (frame_start) begin
            if (jumping) begin
                w_state_nx = ST_JUMP;
                w_pose_nx  = POSE_W'(N_FRAMES - 1);
                w_hold_nx  = '0;
            end else if (moving) begin
                w_state_nx = ST_WALK;
                if (r_state != ST_WALK) begin
                    w_pose_nx = POSE_W'(1);
                    w_hold_nx = '0;
                end else if (r_hold_cnt == HOLD_W'(FRAME_HOLD - 1)) begin
                    w_hold_nx = '0;
                    w_pose_nx = (r_pose == POSE_W'(N_FRAMES - 2)) ? POSE_W'(1)
                                                                  : r_pose + POSE_W'(1);
                end else begin
                    w_hold_nx = r_hold_cnt + HOLD_W'(1);
                end
            end else begin
                w_state_nx = ST_IDLE;
                w_pose_nx  = '0;
                w_hold_nx  = '0;
            end
        end
    end

`ifdef SPRITE_FLIP_EN
    logic r_facing;

    // Facing direction is sampled with the pose so a frame never mixes both.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_facing <= 1'b0;
        end else if (frame_start) begin
            r_facing <= facing_left;
        end
    end

    // Column select, mirrored when the latched facing points left.
    always_comb begin
        w_col = r_facing ? (ADDR_W'(SPR_W - 1) - ADDR_W'(w_rel_x)) : ADDR_W'(w_rel_x);
    end
`else
    logic w_unused_facing;
    assign w_unused_facing = facing_left;

    // Column select without mirroring.
    always_comb begin
        w_col = ADDR_W'(w_rel_x);
    end
`endif

    // Hit test in 11 bits so a sprite near the right/bottom edge never wraps.
    always_comb begin
        w_x_end = {1'b0, PlayerX} + 11'(SPR_W);
        w_y_end = {1'b0, PlayerY} + 11'(SPR_H);
        w_hit   = (DrawX >= PlayerX) && ({1'b0, DrawX} < w_x_end) &&
                  (DrawY >= PlayerY) && ({1'b0, DrawY} < w_y_end);
        w_rel_x = DrawX - PlayerX;
        w_rel_y = DrawY - PlayerY;
    end

    // Address from the current (pre-update) pose, row and column.
    always_comb begin
        w_row  = ADDR_W'(r_pose) * ADDR_W'(SPR_H) + ADDR_W'(w_rel_y);
        w_addr = w_row * ADDR_W'(SPR_W) + w_col;
    end

    // Stage 0: present the ROM address and remember whether it was a hit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rom_addr <= '0;
            r_hit_d    <= 1'b0;
        end else begin
            r_rom_addr <= w_hit ? w_addr : '0;
            r_hit_d    <= w_hit;
        end
    end

    // Stage 1: capture the ROM data, masked to transparent outside the box.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_is_player  <= 1'b0;
            r_stand_data <= '0;
        end else begin
            r_is_player  <= r_hit_d;
            r_stand_data <= r_hit_d ? rom_data : 5'd0;
        end
    end

    assign rom_addr       = r_rom_addr;
    assign is_player      = r_is_player;
    assign stand_data_out = r_stand_data;

endmodule

// File: tb/tb_player_sprite_fetch.sv
// Bench for player_sprite_fetch: directed spec scenarios followed by random
// pixels/poses, compared with an abstract model (pose derived from a count of
// walking frames) and a behavioural ROM.
module tb_player_sprite_fetch;

    localparam int SPR_W      = 32;
    localparam int SPR_H      = 48;
    localparam int N_FRAMES   = 4;
    localparam int FRAME_HOLD = 8;
    localparam int ADDR_W     = 13;

    logic              Clk;
    logic              Reset;
    logic              frame_start;
    logic [9:0]        DrawX, DrawY, PlayerX, PlayerY;
    logic              moving, jumping, facing_left;
    logic [ADDR_W-1:0] rom_addr;
    logic [4:0]        rom_data;
    logic              is_player;
    logic [4:0]        stand_data_out;

    logic [4:0] rom_mem [0:(1<<ADDR_W)-1];
    assign rom_data = rom_mem[rom_addr];

    player_sprite_fetch #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .N_FRAMES(N_FRAMES),
        .FRAME_HOLD(FRAME_HOLD), .ADDR_W(ADDR_W)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .PlayerX(PlayerX), .PlayerY(PlayerY),
        .moving(moving), .jumping(jumping), .facing_left(facing_left),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .is_player(is_player), .stand_data_out(stand_data_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Abstract model: mode 0 idle, 1 walk, 2 jump; walk_cnt = frames since entering walk.
    int m_mode     = 0;
    int m_walk_cnt = 0;
    bit m_facing   = 0;
    bit prev_hit   = 0;
    int prev_addr  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_pose();
        if (m_mode == 0) return 0;
        if (m_mode == 2) return N_FRAMES - 1;
        return 1 + (m_walk_cnt / FRAME_HOLD) % (N_FRAMES - 2);
    endfunction

    task automatic model_frame();
        if (jumping) begin
            m_mode = 2;
        end else if (moving) begin
            if (m_mode == 1) m_walk_cnt++;
            else m_walk_cnt = 0;
            m_mode = 1;
        end else begin
            m_mode = 0;
        end
        m_facing = facing_left;
    endtask

    task automatic model_reset();
        m_mode = 0; m_walk_cnt = 0; m_facing = 0; prev_hit = 0; prev_addr = 0;
    endtask

    // One clock with the current inputs; checks all three outputs after the edge.
    task automatic step();
        int  dx, dy, px, py, rx, ry, col, addr;
        bit  hit;
        dx = int'(DrawX); dy = int'(DrawY); px = int'(PlayerX); py = int'(PlayerY);
        hit = (dx >= px) && (dx < px + SPR_W) && (dy >= py) && (dy < py + SPR_H);
        rx = dx - px; ry = dy - py;
        col = rx;
`ifdef SPRITE_FLIP_EN
        if (m_facing) col = SPR_W - 1 - rx;
`endif
        addr = hit ? (m_pose() * SPR_H + ry) * SPR_W + col : 0;
        @(posedge Clk);
        if (frame_start) model_frame();
        #1;
        check("rom_addr", 32'(rom_addr), 32'(addr));
        check("is_player", 32'(is_player), 32'(prev_hit));
        check("stand_data", 32'(stand_data_out), prev_hit ? 32'(rom_mem[prev_addr]) : 32'd0);
        prev_hit  = hit;
        prev_addr = addr;
    endtask

    task automatic probe_origin();
        frame_start = 1'b0;
        DrawX = PlayerX; DrawY = PlayerY;
        step();
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        DrawX = 10'd0; DrawY = 10'd0;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        int exp_addr;
        for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = 5'($urandom_range(1, 31));
        Reset = 1'b1; frame_start = 1'b0;
        DrawX = '0; DrawY = '0; PlayerX = '0; PlayerY = '0;
        moving = 1'b0; jumping = 1'b0; facing_left = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_addr", 32'(rom_addr), 32'd0);
        check("reset_is_player", 32'(is_player), 32'd0);
        check("reset_stand", 32'(stand_data_out), 32'd0);
        Reset = 1'b0;
        model_reset();

        // Idle sprite at (100,200): origin pixel, then the first pixel right of the box.
        PlayerX = 10'd100; PlayerY = 10'd200;
        DrawX = 10'd100; DrawY = 10'd200;
        step();
        check("t2_addr", 32'(rom_addr), 32'd0);
        DrawX = 10'd132;
        step();
        check("t2_hit", 32'(is_player), 32'd1);
        check("t2_data", 32'(stand_data_out), 32'(rom_mem[0]));
        step();
        check("t2_miss", 32'(is_player), 32'd0);
        check("t2_miss_data", 32'(stand_data_out), 32'd0);

        // Walk cycle: eight frames per pose, alternating 1 and 2.
        moving = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            pulse_frame();
            probe_origin();
            exp_addr = (((i - 1) / FRAME_HOLD) % 2 == 0) ? 1536 : 3072;
            check("walk_pose", 32'(rom_addr), 32'(exp_addr));
        end

        // Jump wins over moving; dropping both returns to idle.
        jumping = 1'b1;
        pulse_frame();
        probe_origin();
        check("jump_pose", 32'(rom_addr), 32'd4608);
        moving = 1'b0; jumping = 1'b0;
        pulse_frame();
        probe_origin();
        check("idle_pose", 32'(rom_addr), 32'd0);

        // Facing left at the origin pixel.
        facing_left = 1'b1;
        pulse_frame();
        probe_origin();
`ifdef SPRITE_FLIP_EN
        check("facing_addr", 32'(rom_addr), 32'd31);
`else
        check("facing_addr", 32'(rom_addr), 32'd0);
`endif
        facing_left = 1'b0;
        pulse_frame();

        // frame_start on an in-sprite pixel uses the old pose.
        moving = 1'b1;
        frame_start = 1'b1; DrawX = PlayerX; DrawY = PlayerY;
        step();
        frame_start = 1'b0;
        check("fs_old_pose", 32'(rom_addr), 32'd0);
        probe_origin();
        check("fs_new_pose", 32'(rom_addr), 32'd1536);
        moving = 1'b0;
        pulse_frame();

        // Right-edge sprite: last visible column hits, x=0 does not wrap.
        PlayerX = 10'd620; PlayerY = 10'd100; DrawY = 10'd100;
        DrawX = 10'd639;
        step();
        DrawX = 10'd0;
        step();
        step();
        check("edge_nowrap", 32'(is_player), 32'd0);
        DrawX = 10'd639;
        step();
        step();
        check("edge_hit", 32'(is_player), 32'd1);

        // Reset mid-line while is_player is high.
        PlayerX = 10'd300; PlayerY = 10'd50;
        moving = 1'b1;
        repeat (3) pulse_frame();
        DrawX = 10'd305; DrawY = 10'd60;
        step();
        step();
        check("pre_reset_hit", 32'(is_player), 32'd1);
        #3;
        Reset = 1'b1;
        #1;
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_is_player", 32'(is_player), 32'd0);
        check("rst_stand", 32'(stand_data_out), 32'd0);
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        model_reset();
        moving = 1'b0;
        probe_origin();
        check("post_reset_pose", 32'(rom_addr), 32'd0);

        // Random pixels around the sprite with random pose/facing changes.
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                PlayerX = 10'($urandom_range(0, 639));
                PlayerY = 10'($urandom_range(0, 479));
                moving = 1'($urandom_range(0, 3) != 0);
                jumping = 1'($urandom_range(0, 4) == 0);
                facing_left = 1'($urandom_range(0, 1));
            end
            frame_start = 1'($urandom_range(0, 3) == 0);
            DrawX = PlayerX + 10'($urandom_range(0, 40)) - 10'd4;
            DrawY = PlayerY + 10'($urandom_range(0, 56)) - 10'd4;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
